// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM state encoding
// and the default bus geometry.
package riscv_arb_pkg;

  localparam int DEF_DW        = 32;
  localparam int DEF_AW        = 32;
  localparam int DEF_MAX_BURST = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Ownership state that a grant to the given port leads to.
  function automatic arb_state_e own_state(input logic port);
    return port ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's handshake and data bus. The master side drives a transfer;
// the slave side (the arbiter) returns the grant and the read data.
interface dmem_arbiter_if
  import riscv_arb_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) ();

    logic          req;
    logic          lock;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic [DW-1:0] rdata;
    logic          rvalid;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rdata, rvalid
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone requester wins outright; on contention the
// port selected by i_rr wins.
module arb_rr_pick (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_rr,
    output logic o_pick0,
    output logic o_pick1
);

    assign o_pick0 = i_req0 && (!i_req1 || !i_rr);
    assign o_pick1 = i_req1 && (!i_req0 ||  i_rr);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory, with locked
// bursts capped at MAX_BURST grants while the other port is waiting.
module dmem_arbiter
  import riscv_arb_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  m0,
    dmem_arbiter_if.slave  m1,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata
);

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    arb_state_e    r_state;
    logic          r_rr;
    logic [CW-1:0] r_cnt;
    logic          r_locked;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_rvalid0;
    logic          r_rvalid1;

    logic w_pick0;
    logic w_pick1;
    logic w_hold0;
    logic w_hold1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_any_gnt;
    logic w_win;

    arb_rr_pick u_rr_pick (
        .i_req0  (m0.req),
        .i_req1  (m1.req),
        .i_rr    (r_rr),
        .o_pick0 (w_pick0),
        .o_pick1 (w_pick1)
    );

    // A locked owner keeps the bus until it has used MAX_BURST grants while
    // the other port was asking for it.
    assign w_hold0 = (r_state == OWN0) && m0.req && r_locked &&
                     ((r_cnt < CNT_MAX) || !m1.req);
    assign w_hold1 = (r_state == OWN1) && m1.req && r_locked &&
                     ((r_cnt < CNT_MAX) || !m0.req);

    // Grants are gated by reset so that asserting it silences the bus at once.
    assign w_gnt0    = reset && (w_hold0 || (!w_hold1 && w_pick0));
    assign w_gnt1    = reset && (w_hold1 || (!w_hold0 && w_pick1));
    assign w_any_gnt = w_gnt0 || w_gnt1;
    assign w_win     = w_gnt1;

    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign m0.rdata  = r_rdata0;
    assign m1.rdata  = r_rdata1;
    assign m0.rvalid = r_rvalid0;
    assign m1.rvalid = r_rvalid1;

    // NOTE: every output gets a default before the if-chain, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt0) begin
            mem_we    = m0.we;
            mem_addr  = m0.addr;
            mem_wdata = m0.wdata;
        end else if (w_gnt1) begin
            mem_we    = m1.we;
            mem_addr  = m1.addr;
            mem_wdata = m1.wdata;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_rr     <= 1'b0;
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else if (w_any_gnt) begin
            r_state  <= own_state(w_win);
            r_rr     <= ~w_win;
            r_locked <= w_win ? m1.lock : m0.lock;
            if (r_state == own_state(w_win)) begin
                r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
            end else begin
                r_cnt <= CW'(1);
            end
        end else begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end
    end

    // Read return: capture the combinational memory data at the grant edge;
    // rdata keeps its last value between reads. The data registers are reset
    // too, so a read interrupted by reset leaves nothing behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 && !m0.we;
            r_rvalid1 <= w_gnt1 && !m1.we;
            if (w_gnt0 && !m0.we) begin
                r_rdata0 <= mem_rdata;
            end
            if (w_gnt1 && !m1.we) begin
                r_rdata1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// phase, all compared against a cycle-level model of the arbitration rules.
module tb_dmem_arbiter;
    import riscv_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DW(DW), .AW(AW)) m0_if ();
    dmem_arbiter_if #(.DW(DW), .AW(AW)) m1_if ();

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Memory attached to the DUT, and the model's own copy of it.
    logic [DW-1:0] sim_mem [64];
    logic [DW-1:0] ref_mem [64];

    assign mem_rdata = sim_mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) sim_mem[mem_addr[7:2]] <= mem_wdata;

    dmem_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0        (m0_if),
        .m1        (m1_if),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model state: owner (-1 = nobody), round-robin pointer, burst count,
    // lock seen on the last grant, and the expected read-return registers.
    int            m_owner, m_rr, m_cnt, last_g;
    bit            m_locked, in_rst;
    bit            exp_rvalid [2];
    logic [DW-1:0] exp_rdata  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit get_req(input int n);
        return (n == 0) ? m0_if.req : m1_if.req;
    endfunction
    function automatic bit get_lock(input int n);
        return (n == 0) ? m0_if.lock : m1_if.lock;
    endfunction
    function automatic bit get_we(input int n);
        if (n < 0) return 1'b0;
        return (n == 0) ? m0_if.we : m1_if.we;
    endfunction
    function automatic logic [AW-1:0] get_addr(input int n);
        if (n < 0) return '0;
        return (n == 0) ? m0_if.addr : m1_if.addr;
    endfunction
    function automatic logic [DW-1:0] get_wdata(input int n);
        if (n < 0) return '0;
        return (n == 0) ? m0_if.wdata : m1_if.wdata;
    endfunction

    task automatic drive(input int n, input bit req, input bit lock, input bit we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (n == 0) begin
            m0_if.req = req; m0_if.lock = lock; m0_if.we = we;
            m0_if.addr = addr; m0_if.wdata = wdata;
        end else begin
            m1_if.req = req; m1_if.lock = lock; m1_if.we = we;
            m1_if.addr = addr; m1_if.wdata = wdata;
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_cnt = 0; m_locked = 1'b0;
        exp_rvalid[0] = 1'b0; exp_rvalid[1] = 1'b0;
        exp_rdata[0]  = '0;   exp_rdata[1]  = '0;
    endtask

    // Who should be granted this cycle, from the arbitration rules.
    function automatic int expected_grant();
        if (in_rst) return -1;
        if (m_owner >= 0 && m_locked && get_req(m_owner) &&
            (m_cnt < MB || !get_req(1 - m_owner))) return m_owner;
        if (get_req(0) && get_req(1)) return m_rr;
        if (get_req(0)) return 0;
        if (get_req(1)) return 1;
        return -1;
    endfunction

    // One clock cycle: check all outputs at the falling edge, advance the
    // model across the rising edge, return 1 time unit after it.
    task automatic step();
        int            g;
        int            idx;
        logic [AW-1:0] a;
        @(negedge clk);
        g = expected_grant();
        chk("m0_gnt",    64'(m0_if.gnt),    64'(g == 0));
        chk("m1_gnt",    64'(m1_if.gnt),    64'(g == 1));
        chk("mem_we",    64'(mem_we),       64'(get_we(g)));
        chk("mem_addr",  64'(mem_addr),     64'(get_addr(g)));
        chk("mem_wdata", 64'(mem_wdata),    64'(get_wdata(g)));
        chk("m0_rvalid", 64'(m0_if.rvalid), 64'(exp_rvalid[0]));
        chk("m1_rvalid", 64'(m1_if.rvalid), 64'(exp_rvalid[1]));
        chk("m0_rdata",  64'(m0_if.rdata),  64'(exp_rdata[0]));
        chk("m1_rdata",  64'(m1_if.rdata),  64'(exp_rdata[1]));
        if (in_rst) begin
            model_reset();
        end else if (g >= 0) begin
            a   = get_addr(g);
            idx = int'(a[7:2]);
            if (get_we(g)) begin
                ref_mem[idx]  = get_wdata(g);
                exp_rvalid[g] = 1'b0;
            end else begin
                exp_rdata[g]  = ref_mem[idx];
                exp_rvalid[g] = 1'b1;
            end
            exp_rvalid[1 - g] = 1'b0;
            m_cnt    = (m_owner == g) ? ((m_cnt < MB) ? m_cnt + 1 : MB) : 1;
            m_owner  = g;
            m_rr     = 1 - g;
            m_locked = get_lock(g);
        end else begin
            m_owner = -1; m_cnt = 0; m_locked = 1'b0;
            exp_rvalid[0] = 1'b0; exp_rvalid[1] = 1'b0;
        end
        last_g = g;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_both();
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    bit pend [2];

    initial begin
        for (int i = 0; i < 64; i++) begin
            sim_mem[i] = 32'hC0DE_0000 + 32'(i);
            ref_mem[i] = 32'hC0DE_0000 + 32'(i);
        end
        sim_mem[16] = 32'hDEAD_BEEF;
        ref_mem[16] = 32'hDEAD_BEEF;
        model_reset();
        in_rst = 1'b1;
        last_g = -1;

        // Reset state: both ports requesting, yet everything stays quiet.
        reset = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b1, 32'h44, 32'h55);
        drive(1, 1'b1, 1'b1, 1'b1, 32'h48, 32'h66);
        #2;
        chk("rst_m0_gnt",   64'(m0_if.gnt),    64'(0));
        chk("rst_m1_gnt",   64'(m1_if.gnt),    64'(0));
        chk("rst_mem_we",   64'(mem_we),       64'(0));
        chk("rst_mem_addr", 64'(mem_addr),     64'(0));
        chk("rst_mem_wd",   64'(mem_wdata),    64'(0));
        chk("rst_m0_rv",    64'(m0_if.rvalid), 64'(0));
        chk("rst_m1_rd",    64'(m1_if.rdata),  64'(0));
        @(posedge clk); #1;
        idle_both();
        reset  = 1'b1;
        in_rst = 1'b0;

        // Single read of 0x40 by m0.
        drive(0, 1'b1, 1'b0, 1'b0, 32'h40, '0);
        #2 chk("rd_gnt", 64'(m0_if.gnt), 64'(1));
        step();
        idle_both();
        #2 chk("rd_data", 64'(m0_if.rdata), 64'(32'hDEAD_BEEF));
        chk("rd_valid", 64'(m0_if.rvalid), 64'(1));
        step();
        step();

        // Write isolation: m1 writes 0x1234 to 0x80.
        drive(1, 1'b1, 1'b0, 1'b1, 32'h80, 32'h1234);
        #2 chk("wr_mem_we", 64'(mem_we), 64'(1));
        chk("wr_mem_addr", 64'(mem_addr), 64'(32'h80));
        step();
        idle_both();
        step();
        step();

        // Contention without lock: alternate grants starting at m0.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 1'b0, 1'b0, 32'(8 * i), '0);
            drive(1, 1'b1, 1'b0, 1'b0, 32'(8 * i + 4), '0);
            #2 chk("alt_gnt0", 64'(m0_if.gnt), 64'((i % 2) == 0));
            step();
        end
        idle_both();
        step();
        step();

        // Locked m0 write burst; m1 waits from the second cycle on.
        for (int i = 0; i < 9; i++) begin
            drive(0, 1'b1, 1'b1, 1'b1, 32'(4 * i), 32'hA000 + 32'(i));
            if (i >= 1) drive(1, 1'b1, 1'b0, 1'b1, 32'hF0, 32'hB000 + 32'(i));
            #2 chk("burst_gnt0", 64'(m0_if.gnt), 64'(i < 8));
            chk("burst_gnt1", 64'(m1_if.gnt), 64'(i == 8));
            chk("burst_we",   64'(mem_we),    64'(1));
            step();
        end
        idle_both();
        step();

        // Uncontended lock for 12 cycles, then m1 asks: count saturated at 8.
        for (int i = 0; i < 13; i++) begin
            drive(0, 1'b1, 1'b1, 1'b0, 32'(4 * i), '0);
            if (i == 12) drive(1, 1'b1, 1'b0, 1'b0, 32'h40, '0);
            #2 chk("sat_gnt0", 64'(m0_if.gnt), 64'(i < 12));
            step();
        end
        idle_both();
        step();
        step();

        // Randomized traffic; a request is held until it is granted.
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] || last_g == n) begin
                    pend[n] = ($urandom_range(0, 99) < 60);
                    drive(n, pend[n], get_lock(n), 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 63)) << 2, 32'($urandom));
                end
                if (n == 0) m0_if.lock = ($urandom_range(0, 99) < 70);
                else        m1_if.lock = ($urandom_range(0, 99) < 70);
            end
            step();
        end
        idle_both();
        step();
        step();

        // Reset during the third grant of an m1 locked read burst.
        drive(1, 1'b1, 1'b1, 1'b0, 32'h10, '0);
        step();
        step();
        #1 chk("pre_rst_gnt1", 64'(m1_if.gnt), 64'(1));
        reset = 1'b0;
        #1;
        chk("mid_rst_gnt1",   64'(m1_if.gnt),    64'(0));
        chk("mid_rst_gnt0",   64'(m0_if.gnt),    64'(0));
        chk("mid_rst_mem_we", 64'(mem_we),       64'(0));
        chk("mid_rst_addr",   64'(mem_addr),     64'(0));
        chk("mid_rst_rv1",    64'(m1_if.rvalid), 64'(0));
        chk("mid_rst_rd1",    64'(m1_if.rdata),  64'(0));
        in_rst = 1'b1;
        model_reset();
        step();
        step();
        reset  = 1'b1;
        in_rst = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h20, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h24, '0);
        #2 chk("post_rst_gnt0", 64'(m0_if.gnt), 64'(1));
        chk("post_rst_rv1", 64'(m1_if.rvalid), 64'(0));
        step();
        step();
        idle_both();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DW, default 32: data width, bits.
REQ-002 Parameter AW, default 32: address width, bits.
REQ-003 Parameter MAX_BURST, default 8: maximum consecutive locked grants while the other port waits.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-low reset.
REQ-006 Ports mN_req  input  1 (N=0,1): requester N has a transfer pending; held until granted.
REQ-007 Ports mN_lock  input  1: requester N asks to keep ownership next cycle.
REQ-008 Ports mN_we  input  1: 1 = write, 0 = read.
REQ-009 Ports mN_addr  input  AW; mN_wdata  input  DW: transfer address and write data.
REQ-010 Ports mN_gnt  output  1: transfer accepted this cycle.
REQ-011 Ports mN_rdata  output  DW; mN_rvalid  output  1: read data, valid one cycle after a granted read.
REQ-012 Ports mem_we  output  1; mem_addr  output  AW; mem_wdata  output  DW: single-port data memory drive.
REQ-013 Port mem_rdata  input  DW: combinational read data from memory.

Function
REQ-014 Arbiter SHALL hold FSM states IDLE, OWN0, OWN1; a round-robin pointer rr (0 or 1); and a burst counter cnt, 0..MAX_BURST, saturating.
REQ-015 At most one mN_gnt SHALL be high per cycle; gnt is combinational from state, rr, cnt, and requests.
REQ-016 Arbitration rule: if only one port requests, grant it; if both request, grant port rr.
REQ-017 In OWNn, if mn_req=1, mn_lock was 1 on the previous grant, and (cnt<MAX_BURST or the other port is idle), the owner SHALL be granted again regardless of rr.
REQ-018 Otherwise, in OWNn the arbitration rule SHALL apply, with rr pointing to the other port.
REQ-019 On each grant to port N: next state OWNN; cnt <= cnt+1 if N was already the owner, else 1; rr <= 1-N.
REQ-020 In a cycle with no grant, next state SHALL be IDLE and cnt <= 0; rr is unchanged.
REQ-021 Memory drive rules:
- In a granted cycle, mem_addr/mem_wdata SHALL equal the granted port's values.
- mem_we SHALL equal gnt & we.
- With no grant, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-022 A write SHALL complete in its grant cycle; mN_rvalid SHALL stay 0 for writes.
REQ-023 For a granted read, mem_rdata SHALL be registered into mN_rdata at the grant edge; mN_rvalid SHALL be high exactly the following cycle (latency 1).
REQ-024 Back-to-back reads SHALL give one rvalid per grant with no bubble.
REQ-025 mN_rdata SHALL hold its last value while rvalid=0.
REQ-026 The other port's rdata/rvalid SHALL be unaffected by a port's transfer.
REQ-027 Forced handover: when cnt=MAX_BURST and the other port requests, the owner SHALL lose the grant for that cycle even if locked.
REQ-028 Requests with mN_req=0 SHALL be ignored; lock without req has no effect.

Reset
REQ-029 While reset=0, all outputs and state SHALL be forced immediately:
- state=IDLE, rr=0, cnt=0.
- mN_gnt=0, mN_rvalid=0, mN_rdata=0.
- mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset asserted mid-burst or during a pending read SHALL discard the ownership and the read; no rvalid SHALL follow the release of reset.
REQ-031 The first cycle after release SHALL arbitrate from IDLE with m0 favoured.

Structure
REQ-032 Shared package riscv_arb_pkg SHALL hold the FSM state enum (IDLE/OWN0/OWN1) and the default DW, AW, and MAX_BURST constants.
REQ-033 A sub-module arb_rr_pick SHALL compute the two-way round-robin decision from (req0, req1, rr).
REQ-034 FSM, counter, memory mux, and read-return registers SHALL live in dmem_arbiter.

Verification
REQ-035 Single read: m0 reads 0x40 with mem_rdata=0xDEADBEEF -> m0_gnt for 1 cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; m1 outputs idle.
REQ-036 Contention after reset: both ports request reads, no lock -> grants alternate m0, m1, m0, m1 on consecutive cycles; each rvalid is one cycle after its grant.
REQ-037 Locked burst with MAX_BURST=8: m0 locked writes, m1 requesting from cycle 2 -> m0 gets 8 consecutive grants; m1 is granted in cycle 9; mem_we=1 on all 9 cycles.
REQ-038 Uncontended lock: m0 locked for 12 cycles, m1 idle -> 12 consecutive m0 grants; cnt saturates at 8.
REQ-039 Reset mid-burst: reset=0 during m1 read grant cycle 3 -> all outputs 0 immediately; no m1_rvalid after release; the first grant after release goes to m0 when both request.
REQ-040 Write isolation: m1 writes 0x1234 to 0x80 -> mem_we=1, mem_addr=0x80, mem_wdata=0x1234 for one cycle; m1_rvalid stays 0.
